// File: rtl/div4_seq_if.sv
// div4_seq_if: divider bundle; master drives start/A/B, slave returns Q/R/busy/done/div_by_zero
interface div4_seq_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] A, B, Q, R;
  logic busy, done, div_by_zero;
  modport master(output start, A, B, input Q, R, busy, done, div_by_zero);
  modport slave(input start, A, B, output Q, R, busy, done, div_by_zero);
endinterface

// File: rtl/div4_seq.sv
// div4_seq: restoring shift-subtract divider, one quotient bit per clk; ports clk, rst, bus (start/A/B in, Q/R/busy/done/div_by_zero out)
module div4_seq #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  div4_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] d, d_n, q, q_n, r, r_n, qo, qo_n, ro, ro_n;
  logic [WIDTH:0] rs, t;
  logic [CW-1:0] cnt, cnt_n;
  logic dz, dz_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      d <= '0;
      q <= '0;
      r <= '0;
      cnt <= '0;
      qo <= '0;
      ro <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      d <= d_n;
      q <= q_n;
      r <= r_n;
      cnt <= cnt_n;
      qo <= qo_n;
      ro <= ro_n;
      dz <= dz_n;
    end
  end
  always_comb begin
    rs = {r, q[WIDTH-1]};
    t = rs - {1'b0, d};
    state_n = state;
    d_n = d;
    q_n = q;
    r_n = r;
    cnt_n = cnt;
    qo_n = qo;
    ro_n = ro;
    dz_n = dz;
    case (state)
      IDLE: if (bus.start) begin
        if (bus.B != '0) begin
          d_n = bus.B;
          q_n = bus.A;
          r_n = '0;
          cnt_n = CW'(WIDTH);
          dz_n = 1'b0;
          state_n = RUN;
        end else begin
          qo_n = '1;
          ro_n = bus.A;
          dz_n = 1'b1;
          state_n = DONE;
        end
      end
      RUN: begin
        q_n = {q[WIDTH-2:0], ~t[WIDTH]};
        r_n = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          qo_n = q_n;
          ro_n = r_n;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.Q = qo;
  assign bus.R = ro;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_div4_seq.sv
// tb_div4_seq: directed plus random/exhaustive checks of div4_seq against arithmetic reference
module tb_div4_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div4_seq_if #(.WIDTH(4)) bus();
  div4_seq #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  int n_assert = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_acc = 0;
  always @(negedge clk) if (!rst && bus.done) n_done++;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (!bus.done && k < 20) begin
      step;
      k++;
    end
  endtask
  task automatic op(input logic [3:0] a, input logic [3:0] b);
    int lat, nb;
    logic [3:0] eq, er;
    eq = b == 4'd0 ? 4'hf : a / b;
    er = b == 4'd0 ? a : a % b;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    n_acc++;
    lat = 1;
    nb = 0;
    while (!bus.done && lat < 20) begin
      nb += int'(bus.busy);
      bus.A = 4'($urandom);
      bus.B = 4'($urandom);
      step;
      lat++;
    end
    chk("latency", lat, b == 4'd0 ? 1 : 5);
    chk("busy_cycles", nb, b == 4'd0 ? 0 : 4);
    chk("Q", bus.Q, eq);
    chk("R", bus.R, er);
    chk("div_by_zero", bus.div_by_zero, b == 4'd0);
    step;
    chk("done_low_after", bus.done, 0);
  endtask
  initial begin
    int k, nd;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    step;
    step;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_Q", bus.Q, 0);
    chk("rst_R", bus.R, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    rst = 1'b0;
    step;
    op(13, 3);
    op(15, 1);
    op(2, 7);
    op(0, 5);
    op(15, 15);
    op(9, 0);
    op(6, 2);
    bus.A = 13;
    bus.B = 3;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    n_acc++;
    step;
    bus.A = 4;
    bus.B = 2;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    wait_done(k);
    chk("ignored_start_wait", k, 2);
    chk("ignored_start_Q", bus.Q, 4);
    chk("ignored_start_R", bus.R, 1);
    step;
    step;
    chk("ignored_start_no_extra_done", bus.done, 0);
    chk("ignored_start_idle", bus.busy, 0);
    bus.A = 13;
    bus.B = 3;
    bus.start = 1'b1;
    step;
    n_acc++;
    wait_done(k);
    chk("held_first_wait", k, 4);
    k = 0;
    do begin
      step;
      k++;
    end while (!bus.done && k < 20);
    n_acc++;
    chk("held_gap", k, 6);
    chk("held_Q", bus.Q, 4);
    bus.start = 1'b0;
    step;
    bus.A = 14;
    bus.B = 4;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_Q", bus.Q, 0);
    chk("abort_R", bus.R, 0);
    nd = n_done;
    repeat (6) step;
    chk("abort_no_done", n_done, nd);
    op(14, 4);
    repeat (40) op(4'($urandom), 4'($urandom));
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(4'(a), 4'(b));
    chk("done_count", n_done, n_acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
